pe_feeder: RTL and testbench

- Initiator side of the PE start/done interface: holds one job's ifmap and filter operands locally.
- On a job request it clears the PE, streams the operands into it with `start` asserted, and flushes the PE's 2-stage multiplier pipeline.
- It then captures `output_psum`, adds a per-job bias and returns the result over a valid/ready handshake.
- Sits between the array controller or host and a single PE instance.

---
 rtl/pe_feeder.sv | 196 +++++++++++++++++++
 tb/tb_pe_feeder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_feeder.sv
// Initiator side of the PE start/done interface: buffers one job's operands, clears and
// streams them into a PE, flushes its multiplier pipeline and returns psum + bias.
module pe_feeder #(
    parameter int unsigned DEPTH = 12,
    parameter int unsigned IF_W  = 16,
    parameter int unsigned FL_W  = 64,
    parameter int unsigned PS_W  = 64,
    parameter int unsigned AW    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [IF_W-1:0] wr_ifmap,
    input  logic [FL_W-1:0] wr_filt,
    input  logic            job_valid,
    output logic            job_ready,
    input  logic [AW:0]     job_len,
    input  logic [PS_W-1:0] job_bias,
    output logic            pe_clear,
    output logic            pe_start,
    output logic [IF_W-1:0] pe_ifmap,
    output logic [FL_W-1:0] pe_filt,
    output logic [PS_W-1:0] pe_input_psum,
    input  logic [PS_W-1:0] pe_output_psum,
    input  logic            pe_done,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [PS_W-1:0] res_psum,
    output logic            res_err
);

    localparam int unsigned CW = AW + 3;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StCapture,
        StResult
    } state_e;

    state_e state_q, state_d;

    logic [AW-1:0]   idx_q, idx_d;
    logic            phase_q, phase_d;
    logic [AW:0]     len_q, len_d;
    logic [PS_W-1:0] bias_q, bias_d;
    logic [CW-1:0]   done_cnt_q, done_cnt_d;
    logic [CW-1:0]   done_inc;
    logic [PS_W-1:0] res_psum_q, res_psum_d;
    logic            res_err_q, res_err_d;

    logic            pe_clear_q, pe_clear_d;
    logic            pe_start_q, pe_start_d;
    logic [IF_W-1:0] pe_ifmap_q, pe_ifmap_d;
    logic [FL_W-1:0] pe_filt_q, pe_filt_d;

    logic [IF_W-1:0] ifmap_mem [DEPTH];
    logic [FL_W-1:0] filt_mem  [DEPTH];

    // Operand buffer: writable only while idle, never reset.
    always_ff @(posedge clk) begin
        if (state_q == StIdle && wr_en && ({1'b0, wr_addr} < DEPTH_W)) begin
            ifmap_mem[wr_addr] <= wr_ifmap;
            filt_mem[wr_addr]  <= wr_filt;
        end
    end

    // Saturating so stray done pulses cannot wrap back to a matching count.
    assign done_inc = (done_cnt_q == '1) ? done_cnt_q : done_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        phase_d    = phase_q;
        len_d      = len_q;
        bias_d     = bias_q;
        done_cnt_d = done_cnt_q;
        res_psum_d = res_psum_q;
        res_err_d  = res_err_q;

        unique case (state_q)
            StIdle: begin
                if (job_valid) begin
                    len_d   = job_len;
                    bias_d  = job_bias;
                    idx_d   = '0;
                    phase_d = 1'b0;
                    if (job_len > DEPTH_W) begin
                        state_d    = StResult;
                        res_psum_d = job_bias;
                        res_err_d  = 1'b1;
                    end else if (job_len == '0) begin
                        state_d    = StResult;
                        res_psum_d = job_bias;
                        res_err_d  = 1'b0;
                    end else begin
                        state_d = StClear;
                    end
                end
            end
            StClear: begin
                done_cnt_d = '0;
                if (phase_q) begin
                    state_d = StStream;
                    idx_d   = '0;
                    phase_d = 1'b0;
                end else begin
                    phase_d = 1'b1;
                end
            end
            StStream: begin
                if (pe_done) done_cnt_d = done_inc;
                if ({1'b0, idx_q} == len_q - 1'b1) begin
                    state_d = StDrain;
                    phase_d = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDrain: begin
                if (pe_done) done_cnt_d = done_inc;
                if (phase_q) begin
                    state_d = StCapture;
                    phase_d = 1'b0;
                end else begin
                    phase_d = 1'b1;
                end
            end
            StCapture: begin
                if (pe_done) done_cnt_d = done_inc;
                res_psum_d = pe_output_psum + bias_q;
                res_err_d  = (done_cnt_d != (CW'(len_q) + CW'(2)));
                state_d    = StResult;
            end
            StResult: begin
                if (res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // PE drive is registered: computed from the state being entered.
        pe_clear_d = (state_d == StClear);
        pe_start_d = (state_d == StStream) || (state_d == StDrain);
        pe_ifmap_d = '0;
        pe_filt_d  = '0;
        if (state_d == StStream) begin
            pe_ifmap_d = ifmap_mem[idx_d];
            pe_filt_d  = filt_mem[idx_d];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            phase_q    <= 1'b0;
            len_q      <= '0;
            bias_q     <= '0;
            done_cnt_q <= '0;
            res_psum_q <= '0;
            res_err_q  <= 1'b0;
            pe_clear_q <= 1'b0;
            pe_start_q <= 1'b0;
            pe_ifmap_q <= '0;
            pe_filt_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            len_q      <= len_d;
            bias_q     <= bias_d;
            done_cnt_q <= done_cnt_d;
            res_psum_q <= res_psum_d;
            res_err_q  <= res_err_d;
            pe_clear_q <= pe_clear_d;
            pe_start_q <= pe_start_d;
            pe_ifmap_q <= pe_ifmap_d;
            pe_filt_q  <= pe_filt_d;
        end
    end

    assign job_ready     = (state_q == StIdle);
    assign res_valid     = (state_q == StResult);
    assign res_psum      = res_psum_q;
    assign res_err       = res_err_q;
    assign pe_clear      = pe_clear_q;
    assign pe_start      = pe_start_q;
    assign pe_ifmap      = pe_ifmap_q;
    assign pe_filt       = pe_filt_q;
    assign pe_input_psum = bias_q;

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder with a behavioural 2-stage-multiplier PE attached.
module tb_pe_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_ifmap;
    logic [63:0] wr_filt;
    logic        job_valid;
    logic        job_ready;
    logic [4:0]  job_len;
    logic [63:0] job_bias;
    logic        pe_clear;
    logic        pe_start;
    logic [15:0] pe_ifmap;
    logic [63:0] pe_filt;
    logic [63:0] pe_input_psum;
    logic [63:0] pe_output_psum;
    logic        pe_done;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_psum;
    logic        res_err;

    int n_pass = 0;
    int n_total = 0;
    int lat;
    logic [63:0] got_psum;
    logic        got_err;
    logic        drop_en = 1'b0;
    logic        start_seen = 1'b0;

    always #5 clk = ~clk;

    pe_feeder dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_ifmap       (wr_ifmap),
        .wr_filt        (wr_filt),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_len        (job_len),
        .job_bias       (job_bias),
        .pe_clear       (pe_clear),
        .pe_start       (pe_start),
        .pe_ifmap       (pe_ifmap),
        .pe_filt        (pe_filt),
        .pe_input_psum  (pe_input_psum),
        .pe_output_psum (pe_output_psum),
        .pe_done        (pe_done),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_psum       (res_psum),
        .res_err        (res_err)
    );

    // PE model: unsigned 16x16 product, two multiplier stages, then accumulate.
    logic [31:0] m1, m2;
    logic [63:0] acc;
    always @(posedge clk or posedge reset) begin
        if (reset || pe_clear) begin
            m1 <= '0; m2 <= '0; acc <= '0;
        end else if (pe_start) begin
            m1  <= pe_ifmap * pe_filt[15:0];
            m2  <= m1;
            acc <= acc + {32'd0, m2};
        end
    end
    assign pe_output_psum = acc;
    // Fault injection: drop the done pulse on the cycle carrying ifmap==3.
    assign pe_done = pe_start && !(drop_en && pe_ifmap == 16'd3);

    always @(posedge clk) if (pe_start) start_seen <= 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic write_buf(input logic [3:0] a, input logic [15:0] i, input logic [63:0] f);
        wr_en = 1'b1; wr_addr = a; wr_ifmap = i; wr_filt = f;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Accept a job, then wait (bounded) for res_valid; lat = edges after acceptance.
    task automatic run_job(input logic [4:0] len, input logic [63:0] bias);
        job_len = len; job_bias = bias; job_valid = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        got_psum = res_psum;
        got_err  = res_err;
    endtask

    task automatic release_res;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_ifmap = '0; wr_filt = '0;
        job_valid = 1'b0; job_len = '0; job_bias = '0; res_ready = 1'b0;
        #12;
        check("rst_job_ready", 64'(job_ready), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_pe_start", 64'(pe_start), 64'd0);
        check("rst_pe_clear", 64'(pe_clear), 64'd0);
        check("rst_res_psum", res_psum, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic job; upper filter bits must not affect the product.
        write_buf(4'd0, 16'd2, 64'hDEAD_0000_0000_0005);
        write_buf(4'd1, 16'd3, 64'h0000_BEEF_0000_0006);
        write_buf(4'd2, 16'd4, 64'h0000_0000_0001_0007);
        run_job(5'd3, 64'd0);
        check("j1_latency", 64'(lat), 64'd8);
        check("j1_psum", got_psum, 64'd56);
        check("j1_err", 64'(got_err), 64'd0);
        release_res();
        check("j1_back_idle", 64'(job_ready), 64'd1);

        // Two biased jobs back to back: CLEAR must discard the old accumulation.
        run_job(5'd3, 64'd100);
        check("j2_psum", got_psum, 64'd156);
        check("j2_input_psum", pe_input_psum, 64'd100);
        release_res();
        run_job(5'd3, 64'd100);
        check("j3_psum", got_psum, 64'd156);
        check("j3_err", 64'(got_err), 64'd0);
        release_res();

        // Result hold under back-pressure; a write during it must be ignored.
        run_job(5'd3, 64'd0);
        wr_en = 1'b1; wr_addr = 4'd0; wr_ifmap = 16'd9; wr_filt = 64'd9;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            wr_en = 1'b0;
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_psum", res_psum, 64'd56);
            check("hold_job_ready", 64'(job_ready), 64'd0);
        end
        release_res();
        check("hold_release_idle", 64'(job_ready), 64'd1);
        run_job(5'd3, 64'd0);
        check("write_ignored_psum", got_psum, 64'd56);
        release_res();

        // Reset in STREAM, then a fresh job still works.
        job_len = 5'd3; job_bias = 64'd5; job_valid = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("mid_streaming", 64'(pe_start), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_job_ready", 64'(job_ready), 64'd1);
        check("mid_rst_pe_start", 64'(pe_start), 64'd0);
        check("mid_rst_pe_ifmap", 64'(pe_ifmap), 64'd0);
        check("mid_rst_input_psum", pe_input_psum, 64'd0);
        check("mid_rst_res_psum", res_psum, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_job(5'd3, 64'd0);
        check("post_rst_psum", got_psum, 64'd56);
        check("post_rst_err", 64'(got_err), 64'd0);
        release_res();

        // Missing done pulse flags an error but the sum is still formed.
        drop_en = 1'b1;
        run_job(5'd3, 64'd0);
        drop_en = 1'b0;
        check("drop_done_err", 64'(got_err), 64'd1);
        check("drop_done_psum", got_psum, 64'd56);
        release_res();

        // Zero-length job: bias returned, PE never started.
        start_seen = 1'b0;
        run_job(5'd0, 64'd7);
        check("len0_latency", 64'(lat), 64'd0);
        check("len0_psum", got_psum, 64'd7);
        check("len0_err", 64'(got_err), 64'd0);
        release_res();
        check("len0_no_start", 64'(start_seen), 64'd0);

        // Over-length job.
        run_job(5'd13, 64'd42);
        check("len13_psum", got_psum, 64'd42);
        check("len13_err", 64'(got_err), 64'd1);
        release_res();
        check("len13_no_start", 64'(start_seen), 64'd0);

        // Full depth with maximal operands.
        for (int i = 0; i < 12; i++) write_buf(4'(i), 16'hFFFF, 64'h0000_0000_0000_FFFF);
        run_job(5'd12, 64'd0);
        check("full_latency", 64'(lat), 64'd17);
        check("full_psum", got_psum, 64'h0000_000B_FFE8_000C);
        check("full_err", 64'(got_err), 64'd0);
        release_res();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
